// File: rtl/sim_end_sequencer.sv
// Run-control sequencer for the simulation harness: holds the DUT in reset, counts trace
// cycles, latches a single end-of-test verdict, gates wave dumping and requests finish.
module sim_end_sequencer #(
   parameter  int NUM_SRC      = 4,
   parameter  int CODE_W       = 8,
   parameter  int CNT_W        = 64,
   parameter  int DRAIN_CYCLES = 16,
   localparam int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [15:0]               cfg_reset_hold,
   input  logic [CNT_W-1:0]          cfg_max_cycles,
   input  logic [CNT_W-1:0]          cfg_dump_start,
   input  logic [CNT_W-1:0]          cfg_dump_len,
   input  logic [NUM_SRC-1:0]        src_done,
   input  logic [NUM_SRC-1:0]        src_fail,
   input  logic [NUM_SRC*CODE_W-1:0] src_code,
   output logic                      dut_reset,
   output logic                      dump_en,
   output logic [CNT_W-1:0]          trace_count,
   output logic                      verdict_valid,
   output logic [1:0]                verdict,
   output logic [SRC_W-1:0]          exit_src,
   output logic [CODE_W-1:0]         exit_code,
   output logic                      finish_req
);

   typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [1:0]  V_NONE = 2'd0, V_PASS = 2'd1, V_FAIL = 2'd2, V_TMO = 2'd3;
   localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    trace_q, trace_d, trace_inc;
   logic [31:0]         phase_q, phase_d;
   logic [CNT_W-1:0]    max_q, max_d, dstart_q, dstart_d, dlen_q, dlen_d;
   logic                vvalid_q, vvalid_d;
   logic [1:0]          verdict_q, verdict_d;
   logic [SRC_W-1:0]    src_q, src_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                dut_reset_q, dut_reset_d;
   logic                dump_q, dump_d;
   logic                finish_q, finish_d;

   logic                any_fail, any_done, timeout;
   logic [SRC_W-1:0]    fail_idx, done_idx;
   logic [CODE_W-1:0]   fail_code, done_code;

   // Lowest-index source wins; scanning downward leaves the lowest match last.
   always_comb begin
      fail_idx  = '0;
      fail_code = '0;
      done_idx  = '0;
      done_code = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_fail[i]) begin
            fail_idx  = SRC_W'(i);
            fail_code = src_code[i*CODE_W +: CODE_W];
         end
         if (src_done[i]) begin
            done_idx  = SRC_W'(i);
            done_code = src_code[i*CODE_W +: CODE_W];
         end
      end
   end

   assign any_fail  = |src_fail;
   assign any_done  = |src_done;
   assign timeout   = (max_q != '0) && (trace_q >= max_q);
   assign trace_inc = (&trace_q) ? trace_q : trace_q + 1'b1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         trace_q     <= '0;
         phase_q     <= '0;
         max_q       <= '0;
         dstart_q    <= '0;
         dlen_q      <= '0;
         vvalid_q    <= 1'b0;
         verdict_q   <= V_NONE;
         src_q       <= '0;
         code_q      <= '0;
         dut_reset_q <= 1'b1;
         dump_q      <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         trace_q     <= trace_d;
         phase_q     <= phase_d;
         max_q       <= max_d;
         dstart_q    <= dstart_d;
         dlen_q      <= dlen_d;
         vvalid_q    <= vvalid_d;
         verdict_q   <= verdict_d;
         src_q       <= src_d;
         code_q      <= code_d;
         dut_reset_q <= dut_reset_d;
         dump_q      <= dump_d;
         finish_q    <= finish_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      trace_d   = trace_q;
      phase_d   = phase_q;
      max_d     = max_q;
      dstart_d  = dstart_q;
      dlen_d    = dlen_q;
      vvalid_d  = vvalid_q;
      verdict_d = verdict_q;
      src_d     = src_q;
      code_d    = code_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_HOLD;
               trace_d   = '0;
               // phase counts remaining HOLD cycles minus one; hold of 0 behaves as 1
               phase_d   = (cfg_reset_hold == 16'd0) ? 32'd0 : {16'd0, cfg_reset_hold - 16'd1};
               max_d     = cfg_max_cycles;
               dstart_d  = cfg_dump_start;
               dlen_d    = cfg_dump_len;
               vvalid_d  = 1'b0;
               verdict_d = V_NONE;
               src_d     = '0;
               code_d    = '0;
            end
         end
         S_HOLD: begin
            trace_d = trace_inc;
            if (phase_q == 32'd0) state_d = S_RUN;
            else                  phase_d = phase_q - 32'd1;
         end
         S_RUN: begin
            trace_d = trace_inc;
            if (any_fail || timeout || any_done) begin
               vvalid_d = 1'b1;
               if (any_fail) begin
                  verdict_d = V_FAIL;
                  src_d     = fail_idx;
                  code_d    = fail_code;
               end else if (timeout) begin
                  verdict_d = V_TMO;
                  src_d     = '0;
                  code_d    = '0;
               end else begin
                  verdict_d = V_PASS;
                  src_d     = done_idx;
                  code_d    = done_code;
               end
               if (DRAIN_CYCLES == 0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DRAIN;
                  phase_d = DRAIN_LOAD;
               end
            end
         end
         S_DRAIN: begin
            trace_d = trace_inc;
            if (phase_q == 32'd0) state_d = S_DONE;
            else                  phase_d = phase_q - 32'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output flops are fed from next-state values so they line up with trace_count.
   always_comb begin
      dut_reset_d = !(state_d == S_RUN || state_d == S_DRAIN);
      finish_d    = (state_d == S_DONE);
      dump_d      = (state_d == S_HOLD || state_d == S_RUN || state_d == S_DRAIN) &&
                    (trace_d >= dstart_d) &&
                    ((dlen_d == '0) || ((trace_d - dstart_d) < dlen_d));
   end

   assign dut_reset     = dut_reset_q;
   assign dump_en       = dump_q;
   assign trace_count   = trace_q;
   assign verdict_valid = vvalid_q;
   assign verdict       = verdict_q;
   assign exit_src      = src_q;
   assign exit_code     = code_q;
   assign finish_req    = finish_q;

endmodule

// File: tb/tb_sim_end_sequencer.sv
// Bench for sim_end_sequencer: per-run timeline predicted from cycle arithmetic
// (hold length, first end event, drain length) and compared every cycle.
module tb_sim_end_sequencer;
   localparam int NS = 4, CW = 8, CNW = 64, DR = 16;

   logic             clock = 1'b0, reset = 1'b0, start = 1'b0;
   logic [15:0]      cfg_reset_hold = '0;
   logic [CNW-1:0]   cfg_max_cycles = '0, cfg_dump_start = '0, cfg_dump_len = '0;
   logic [NS-1:0]    src_done = '0, src_fail = '0;
   logic [NS*CW-1:0] src_code = '0;
   logic             dut_reset, dump_en, verdict_valid, finish_req;
   logic [CNW-1:0]   trace_count;
   logic [1:0]       verdict, exit_src;
   logic [CW-1:0]    exit_code;

   int checks = 0, errors = 0;

   sim_end_sequencer #(.NUM_SRC(NS), .CODE_W(CW), .CNT_W(CNW), .DRAIN_CYCLES(DR)) dut (
      .clock(clock), .reset(reset), .start(start), .cfg_reset_hold(cfg_reset_hold),
      .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start), .cfg_dump_len(cfg_dump_len),
      .src_done(src_done), .src_fail(src_fail), .src_code(src_code),
      .dut_reset(dut_reset), .dump_en(dump_en), .trace_count(trace_count),
      .verdict_valid(verdict_valid), .verdict(verdict), .exit_src(exit_src),
      .exit_code(exit_code), .finish_req(finish_req));

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives one full run from start to a few cycles past DONE and predicts every cycle.
   task automatic run_scenario(input string name, input int hold, input logic [CNW-1:0] maxc,
                               input logic [CNW-1:0] ds, input logic [CNW-1:0] dl,
                               input int t_ev, input logic [NS-1:0] fm, input logic [NS-1:0] dm,
                               input int k_start);
      int n, tv, tdone;
      logic [1:0] v_e, s_e;
      logic [CW-1:0] c_e;
      logic [CNW-1:0] tcv;
      logic [79:0] act, exp;
      logic du_e;
      n  = (hold == 0) ? 1 : hold;
      tv = -1;
      for (int t = n; t < n + 5000; t++)
         if ((t == t_ev && (fm | dm) != 0) || (maxc != 0 && CNW'(t) >= maxc)) begin
            tv = t;
            break;
         end
      if (tv < 0) begin
         $display("FAIL %s: scenario never ends (act none, exp an end event)", name);
         $fatal(1, "bad scenario");
      end
      s_e = '0;
      if (t_ev == tv && fm != 0) begin
         v_e = 2'd2;
         for (int i = NS - 1; i >= 0; i--) if (fm[i]) s_e = 2'(i);
         c_e = src_code[s_e*CW +: CW];
      end else if (maxc != 0 && CNW'(tv) >= maxc) begin
         v_e = 2'd3;
         c_e = '0;
      end else begin
         v_e = 2'd1;
         for (int i = NS - 1; i >= 0; i--) if (dm[i]) s_e = 2'(i);
         c_e = src_code[s_e*CW +: CW];
      end
      tdone = tv + 1 + DR;

      cfg_reset_hold = 16'(hold);
      cfg_max_cycles = maxc;
      cfg_dump_start = ds;
      cfg_dump_len   = dl;
      src_fail = '0;
      src_done = '0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k <= tdone + 2; k++) begin
         tcv  = CNW'((k < tdone) ? k : tdone);
         du_e = (k < tdone) && (tcv >= ds) && (dl == 0 || (tcv - ds) < dl);
         exp  = {(k < n || k >= tdone), du_e, tcv, (k > tv),
                 (k > tv) ? v_e : 2'd0, (k > tv) ? s_e : 2'd0, (k > tv) ? c_e : 8'd0,
                 (k >= tdone)};
         act  = {dut_reset, dump_en, trace_count, verdict_valid, verdict, exit_src,
                 exit_code, finish_req};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
         end
         // config is only honoured at the start edge
         cfg_reset_hold = 16'($urandom);
         cfg_max_cycles = {$urandom, $urandom};
         cfg_dump_start = CNW'($urandom_range(0, 40));
         cfg_dump_len   = CNW'($urandom_range(0, 9));
         start = (k == k_start && k < tdone);
         if (k == t_ev) begin
            src_fail = fm;
            src_done = dm;
         end else if (k < n || k > tv) begin
            src_fail = (k == tv + 2) ? 4'hF : 4'($urandom);
            src_done = 4'($urandom);
         end else begin
            src_fail = '0;
            src_done = '0;
         end
         step();
      end
      start = 1'b0;
      src_fail = '0;
      src_done = '0;
   endtask

   task automatic test_reset();
      logic [79:0] act;
      reset = 1'b0;
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      act = {dut_reset, dump_en, trace_count, verdict_valid, verdict, exit_src, exit_code, finish_req};
      checks++;
      if (act !== {2'b10, 64'd0, 14'd0}) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", act, {2'b10, 64'd0, 14'd0});
      end
      reset = 1'b1;
      step();
      step();
      act = {dut_reset, dump_en, trace_count, verdict_valid, verdict, exit_src, exit_code, finish_req};
      checks++;
      if (act !== {2'b10, 64'd0, 14'd0}) begin
         errors++;
         $display("FAIL idle_no_start: got %h expected %h", act, {2'b10, 64'd0, 14'd0});
      end
   endtask

   task automatic test_hold_pass();
      src_code = 32'h44332211;
      run_scenario("hold_pass", 5, 0, 64'd1000, 0, 40, 4'b0000, 4'b0100, 12);
      checks++;
      if ({verdict, exit_src, exit_code, finish_req} !== {2'd1, 2'd2, 8'h33, 1'b1}) begin
         errors++;
         $display("FAIL hold_pass_verdict: got %0d/%0d/%h expected 1/2/33",
                  verdict, exit_src, exit_code);
      end
   endtask

   task automatic test_simultaneous();
      src_code = 32'h22AA11BB;
      run_scenario("simultaneous", 3, 0, 0, 0, 20, 4'b1010, 4'b0001, -1);
      checks++;
      if ({verdict, exit_src, exit_code} !== {2'd2, 2'd1, 8'h11}) begin
         errors++;
         $display("FAIL simultaneous_verdict: got %0d/%0d/%h expected 2/1/11",
                  verdict, exit_src, exit_code);
      end
   endtask

   task automatic test_timeout();
      run_scenario("timeout", 4, 64'd100, 64'd90, 0, -1, 4'b0000, 4'b0000, 50);
      checks++;
      if ({verdict, exit_src, exit_code, trace_count} !== {2'd3, 2'd0, 8'h00, 64'd117}) begin
         errors++;
         $display("FAIL timeout_verdict: got %0d/%0d/%h tc=%0d expected 3/0/00 tc=117",
                  verdict, exit_src, exit_code, trace_count);
      end
   endtask

   task automatic test_fail_beats_timeout();
      src_code = 32'h0102035A;
      run_scenario("fail_vs_timeout", 2, 64'd60, 0, 0, 60, 4'b0001, 4'b0110, -1);
      checks++;
      if ({verdict, exit_code} !== {2'd2, 8'h5A}) begin
         errors++;
         $display("FAIL fail_vs_timeout_verdict: got %0d/%h expected 2/5a", verdict, exit_code);
      end
   endtask

   task automatic test_dump_window();
      run_scenario("dump_len5", 6, 0, 64'd10, 64'd5, 30, 4'b0000, 4'b1000, -1);
      run_scenario("dump_unbounded", 6, 0, 64'd10, 64'd0, 30, 4'b0000, 4'b1000, 8);
   endtask

   task automatic test_reset_midrun();
      logic [79:0] act;
      cfg_reset_hold = 16'd3;
      cfg_max_cycles = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (dut_reset !== 1'b0) begin
         errors++;
         $display("FAIL midrun_in_run: dut_reset got %b expected 0", dut_reset);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      act = {dut_reset, dump_en, trace_count, verdict_valid, verdict, exit_src, exit_code, finish_req};
      checks++;
      if (act !== {2'b10, 64'd0, 14'd0}) begin
         errors++;
         $display("FAIL midrun_reset: got %h expected %h", act, {2'b10, 64'd0, 14'd0});
      end
      src_fail = 4'hF;
      step();
      step();
      src_fail = '0;
      act = {dut_reset, dump_en, trace_count, verdict_valid, verdict, exit_src, exit_code, finish_req};
      checks++;
      if (act !== {2'b10, 64'd0, 14'd0}) begin
         errors++;
         $display("FAIL midrun_stays_idle: got %h expected %h", act, {2'b10, 64'd0, 14'd0});
      end
   endtask

   task automatic test_restart_from_done();
      src_code = 32'hC0FFEE77;
      run_scenario("restart_first", 2, 64'd45, 64'd5, 64'd3, 25, 4'b0100, 4'b0000, 3);
      run_scenario("restart_hold0", 0, 0, 64'd0, 64'd2, 9, 4'b0000, 4'b0011, -1);
   endtask

   task automatic test_random();
      int hold, t_ev;
      logic [CNW-1:0] maxc;
      logic [NS-1:0] fm, dm;
      for (int r = 0; r < 10; r++) begin
         src_code = $urandom;
         hold = $urandom_range(0, 12);
         maxc = ($urandom_range(0, 1) == 1) ? CNW'($urandom_range(5, 150)) : '0;
         t_ev = $urandom_range(0, 140);
         fm   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         dm   = 4'($urandom);
         if (maxc == 0) begin
            if (t_ev < 13) t_ev = 13 + t_ev;
            if ((fm | dm) == 0) dm = 4'b0100;
         end
         run_scenario($sformatf("random%0d", r), hold, maxc, CNW'($urandom_range(0, 60)),
                      CNW'($urandom_range(0, 20)), t_ev, fm, dm, $urandom_range(0, 100));
      end
   endtask

   initial begin
      test_reset();
      test_hold_pass();
      test_simultaneous();
      test_timeout();
      test_fail_beats_timeout();
      test_dump_window();
      test_reset_midrun();
      test_restart_from_done();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sim_end_sequencer.md
Name: sim_end_sequencer

Overview:
- Synthesizable run-control block for the simulation harness. Holds the DUT in reset for a programmed number of cycles, then releases it and counts trace cycles.
- Arbitrates end-of-test reports from NUM_SRC harness status sources, a cycle timeout and a success indication into one latched verdict.
- Gates waveform dumping to a cycle window, and raises a finish request after a drain period.
- Sits between the top-level test driver and the test harness.

Parameters:
- NUM_SRC, 4, number of end-of-test status sources.
- CODE_W, 8, width of each source's exit code.
- CNT_W, 64, width of the trace counter and cycle config values.
- DRAIN_CYCLES, 16, cycles between verdict latch and finish_req; 0 allowed.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  pulse; begins a run from IDLE or DONE.
- cfg_reset_hold  in  16  DUT reset cycles; 0 treated as 1.
- cfg_max_cycles  in  CNT_W  timeout threshold; 0 disables.
- cfg_dump_start  in  CNT_W  first trace cycle with dump_en=1.
- cfg_dump_len  in  CNT_W  dump window length; 0 means unbounded.
- src_done  in  NUM_SRC  per-source success report.
- src_fail  in  NUM_SRC  per-source failure report.
- src_code  in  NUM_SRC*CODE_W  per-source exit code; source i occupies bits [i*CODE_W +: CODE_W].
- dut_reset  out  1  active-high reset to harness.
- dump_en  out  1  waveform dump enable.
- trace_count  out  CNT_W  cycles since start.
- verdict_valid  out  1  verdict latched.
- verdict  out  2  0 none, 1 pass, 2 fail, 3 timeout.
- exit_src  out  clog2(NUM_SRC) (min 1)  index of winning source.
- exit_code  out  CODE_W  code of winning source.
- finish_req  out  1  simulation may end.

Behaviour:
- Reset (reset==0 at posedge): state IDLE. Outputs: dut_reset=1, dump_en=0, trace_count=0, verdict_valid=0, verdict=0, exit_src=0, exit_code=0, finish_req=0. Reset mid-run aborts the run and needs a new start.
- Config ports are sampled into registers on the start edge and are ignored afterwards.
- States: IDLE, HOLD, RUN, DRAIN, DONE.
- IDLE: dut_reset=1. If start=1 at an edge, next state is HOLD, trace_count=0 and the verdict is cleared.
- HOLD: dut_reset=1 for exactly max(cfg_reset_hold,1) cycles, then RUN. trace_count increments every cycle from HOLD onward.
- RUN: dut_reset=0. Each edge evaluates end events on the registered state; src_* are sampled directly at the edge.
  - any_fail = |src_fail, any_done = |src_done, timeout = (cfg_max_cycles!=0 && trace_count >= cfg_max_cycles).
  - Priority: any_fail > timeout > any_done.
  - Among sources, the lowest index with the relevant bit set wins and sets exit_src/exit_code.
  - On timeout: exit_src=0, exit_code=0, verdict=3.
  - If src_fail[i] and src_done[i] are both set, the source counts as fail.
  - On any event: latch verdict, set verdict_valid=1, next state DRAIN (or DONE if DRAIN_CYCLES==0).
- DRAIN: dut_reset stays 0. Stays exactly DRAIN_CYCLES cycles. Further src_* and timeout are ignored; the verdict never changes once latched.
- DONE: finish_req=1 and verdict held. dut_reset=1 from DONE entry. start=1 re-enters HOLD with verdict and trace_count cleared.
- start in HOLD, RUN or DRAIN is ignored.
- src_* inputs are ignored in IDLE, HOLD, DRAIN and DONE.
- trace_count saturates at all-ones and does not wrap. It is frozen in DONE and IDLE.
- dump_en=1 when state is HOLD, RUN or DRAIN and trace_count >= cfg_dump_start and (cfg_dump_len==0 or trace_count - cfg_dump_start < cfg_dump_len). The subtraction is CNT_W wide and guarded by the first compare. dump_en=0 in IDLE and DONE.
- Outputs are registered; no combinational path from src_* to any output.

Test Plan:
1. Hold and pass.
   - Stimulus: reset_hold=5, max=0, DRAIN=16; start; src_done[2]=1 at trace_count 40.
   - Required response: dut_reset high for 5 cycles after start; verdict=1, exit_src=2; finish_req asserts 16 cycles after verdict_valid.
2. Simultaneous events.
   - Stimulus: src_done[0], src_fail[3] and src_fail[1] asserted in the same RUN cycle, with codes 0x11 and 0x22 on sources 1 and 3.
   - Required response: verdict=2, exit_src=1, exit_code=0x11.
3. Timeout.
   - Stimulus: max_cycles=100, no reports.
   - Required response: verdict=3 latched when trace_count reaches 100; a src_fail arriving during DRAIN leaves the verdict unchanged.
4. Fail beats timeout.
   - Stimulus: src_fail[0] asserted in the same cycle the timeout condition becomes true.
   - Required response: verdict=2.
5. Dump window.
   - Stimulus: dump_start=10, dump_len=5.
   - Required response: dump_en high exactly for trace_count 10..14.
   - Stimulus: dump_len=0.
   - Required response: dump_en high from trace_count 10 until DONE.
6. Reset mid-run and restart.
   - Stimulus: reset=0 during RUN.
   - Required response: next cycle IDLE, dut_reset=1, outputs at reset values.
   - Stimulus: start in DONE.
   - Required response: HOLD with verdict_valid=0, trace_count=0.
   - Stimulus: reset_hold=0.
   - Required response: exactly 1 HOLD cycle.
